pwm_ramp_controller: RTL and testbench

//  Sequences the duty cycle of the PWM datapath.
//  - Derives a 1 MHz tick enable from clk_50MHz and runs the PWM period counter on it.
//  - Accepts target-duty commands over a valid/ready handshake.
//  - Moves the live duty to the target in bounded steps (ramp) or in one jump (immediate).
//  - Duty changes only at period boundaries, so the PWM output never glitches.

---
 rtl/pwm_ramp_controller_pkg.sv | 33 +++
 rtl/pwm_ramp_controller_tick_gen.sv | 51 +++++
 rtl/pwm_ramp_controller.sv | 118 +++++++++++
 tb/tb_pwm_ramp_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_controller_pkg.sv
// Shared types and helpers for the PWM ramp controller: FSM encoding and the
// duty clamp/step arithmetic, done at a fixed wide width to avoid overflow.
package pwm_ramp_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StApply = 2'd1,
    StRamp  = 2'd2
  } state_e;

  localparam int unsigned CalcW = 32;

  function automatic logic [CalcW-1:0] clamp_duty(input logic [CalcW-1:0] duty,
                                                  input logic [CalcW-1:0] limit);
    return (duty > limit) ? limit : duty;
  endfunction

  // Difference is taken before the add/subtract, so the result lands on the
  // target instead of overshooting it or wrapping below zero.
  function automatic logic [CalcW-1:0] step_toward(input logic [CalcW-1:0] cur,
                                                   input logic [CalcW-1:0] tgt,
                                                   input logic [CalcW-1:0] step);
    logic [CalcW-1:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) <= step) ? tgt : (cur + step);
    end else if (cur > tgt) begin
      res = ((cur - tgt) <= step) ? tgt : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_ramp_controller_tick_gen.sv
// Prescaler and PWM period counter; both are held at zero while enable is low.
module pwm_tick_gen #(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned PERIOD   = 100,
  parameter int unsigned DUTY_W   = 8
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              enable,
  output logic              tick,
  output logic [DUTY_W-1:0] pcnt,
  output logic              period_start
);

  localparam int unsigned PrescW = $clog2(TICK_DIV);

  logic [PrescW-1:0] presc_q, presc_d;
  logic [DUTY_W-1:0] pcnt_q, pcnt_d;

  always_comb begin
    tick         = enable && (presc_q == PrescW'(TICK_DIV - 1));
    period_start = tick && (pcnt_q == DUTY_W'(PERIOD - 1));

    presc_d = presc_q;
    pcnt_d  = pcnt_q;
    if (!enable) begin
      presc_d = '0;
      pcnt_d  = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (period_start) begin
        pcnt_d = '0;
      end else if (tick) begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign pcnt = pcnt_q;

endmodule

// File: rtl/pwm_ramp_controller.sv
// PWM duty sequencer: accepts target-duty commands and applies them either as
// a single jump or as a bounded ramp, only ever changing duty at period boundaries.
module pwm_ramp_controller
  import pwm_ramp_controller_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 50,
  parameter int unsigned PERIOD       = 100,
  parameter int unsigned DUTY_W       = 8,
  parameter int unsigned STEP         = 1,
  parameter int unsigned STEP_PERIODS = 4
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              cmd_immediate,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_cur,
  output logic              period_start,
  output logic              busy
);

  localparam int unsigned BcntW = $clog2(STEP_PERIODS + 1);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [BcntW-1:0]  bcnt_q, bcnt_d;
  logic              pwm_q, pwm_d;

  logic              tick;
  logic [DUTY_W-1:0] pcnt;
  logic              boundary;
  logic              accept;
  logic [DUTY_W-1:0] cmd_clamped;

  pwm_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PERIOD   (PERIOD),
    .DUTY_W   (DUTY_W)
  ) u_tick_gen (
    .clk_50MHz    (clk_50MHz),
    .rst_n        (rst_n),
    .enable       (enable),
    .tick         (tick),
    .pcnt         (pcnt),
    .period_start (period_start)
  );

  assign boundary    = tick && period_start;
  assign accept      = cmd_valid && (state_q == StIdle);
  assign cmd_clamped = DUTY_W'(clamp_duty(CalcW'(cmd_duty), CalcW'(PERIOD)));

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    duty_d   = duty_q;
    bcnt_d   = bcnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept && (cmd_clamped != duty_q)) begin
          target_d = cmd_clamped;
          bcnt_d   = '0;
          state_d  = cmd_immediate ? StApply : StRamp;
        end
      end
      StApply: begin
        if (boundary) begin
          duty_d  = target_q;
          state_d = StIdle;
        end
      end
      StRamp: begin
        if (duty_q == target_q) begin
          state_d = StIdle;
        end else if (!enable) begin
          // A disabled interval restarts the step spacing from scratch.
          bcnt_d = '0;
        end else if (boundary) begin
          if (bcnt_q == BcntW'(STEP_PERIODS - 1)) begin
            bcnt_d = '0;
            duty_d = DUTY_W'(step_toward(CalcW'(duty_q), CalcW'(target_q), CalcW'(STEP)));
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    pwm_d = enable && (pcnt < duty_q);
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      target_q <= '0;
      duty_q   <= '0;
      bcnt_q   <= '0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      duty_q   <= duty_d;
      bcnt_q   <= bcnt_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign duty_cur  = duty_q;
  assign busy      = (state_q != StIdle);
  assign cmd_ready = (state_q == StIdle);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Bench for pwm_ramp_controller: directed scenarios plus random commands, all
// checked every cycle against an arithmetic model of the period/duty behaviour.
module tb_pwm_ramp_controller;

  localparam int TD = 2;
  localparam int P  = 10;
  localparam int ST = 2;
  localparam int SP = 1;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_immediate = 1'b0;
  logic [DW-1:0] cmd_duty = '0;
  logic          cmd_ready;
  logic          pwm_out;
  logic [DW-1:0] duty_cur;
  logic          period_start;
  logic          busy;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Model: elapsed enabled cycles m_e (mod one period), mode 0 idle/1 jump/2 ramp.
  int m_mode, m_duty, m_target, m_e, m_nb;
  bit m_pwm;

  pwm_ramp_controller #(
    .TICK_DIV     (TD),
    .PERIOD       (P),
    .DUTY_W       (DW),
    .STEP         (ST),
    .STEP_PERIODS (SP)
  ) dut (
    .clk_50MHz     (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_duty      (cmd_duty),
    .cmd_immediate (cmd_immediate),
    .pwm_out       (pwm_out),
    .duty_cur      (duty_cur),
    .period_start  (period_start),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit ps_exp;
    ps_exp = enable && (m_e == TD * P - 1);
    check("pwm_out", 32'(pwm_out), 32'(m_pwm));
    check("duty_cur", 32'(duty_cur), 32'(m_duty));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("cmd_ready", 32'(cmd_ready), 32'(m_mode == 0));
    check("period_start", 32'(period_start), 32'(ps_exp));
  endtask

  task automatic model_reset();
    m_mode = 0; m_duty = 0; m_target = 0; m_e = 0; m_nb = 0; m_pwm = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    int pc, nd, nmode, nt, ne, nnb, t;
    bit np, bnd, acc;
    pc  = (m_e / TD) % P;
    bnd = enable && (m_e == TD * P - 1);
    np  = enable && (pc < m_duty);
    ne  = enable ? (m_e + 1) % (TD * P) : 0;
    nmode = m_mode; nd = m_duty; nt = m_target; nnb = m_nb;
    acc = (m_mode == 0) && cmd_valid;
    if (m_mode == 0) begin
      if (cmd_valid) begin
        t = (int'(cmd_duty) > P) ? P : int'(cmd_duty);
        if (t != m_duty) begin
          nt = t; nnb = 0; nmode = cmd_immediate ? 1 : 2;
        end
      end
    end else if (m_mode == 1) begin
      if (bnd) begin nd = m_target; nmode = 0; end
    end else begin
      if (m_duty == m_target) nmode = 0;
      else if (!enable) nnb = 0;
      else if (bnd) begin
        nnb = m_nb + 1;
        if (nnb == SP) begin
          nnb = 0;
          if (m_target > m_duty) nd = (m_duty + ST < m_target) ? m_duty + ST : m_target;
          else nd = (m_duty - ST > m_target) ? m_duty - ST : m_target;
        end
      end
    end
    @(posedge clk);
    #1;
    m_mode = nmode; m_duty = nd; m_target = nt; m_e = ne; m_nb = nnb; m_pwm = np;
    check_all();
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int d, input bit imm);
    cmd_duty = DW'(d);
    cmd_immediate = imm;
    cmd_valid = 1'b1;
  endtask

  initial begin
    do_reset();
    // Idle with enable: period_start every TD*P clocks, output low.
    enable = 1'b1;
    run(60);
    // Immediate jump to 5.
    send(5, 1'b1);
    run(60);
    check("duty_after_jump", 32'(duty_cur), 32'd5);
    // Back to 0, then ramp to 7.
    send(0, 1'b1);
    run(30);
    send(7, 1'b0);
    run(100);
    check("duty_after_ramp", 32'(duty_cur), 32'd7);
    // Over-range command clamps to PERIOD, then ramp down to 0.
    send(200, 1'b1);
    run(40);
    check("duty_clamped", 32'(duty_cur), 32'(P));
    send(0, 1'b0);
    run(150);
    // Ramp to 8 with enable dropped mid-ramp.
    send(8, 1'b0);
    for (int i = 0; i < 300; i++) begin
      if (m_duty >= 4) break;
      step();
    end
    check("reached_duty4", 32'(duty_cur), 32'd4);
    enable = 1'b0;
    run(50);
    check("held_duty4", 32'(duty_cur), 32'd4);
    enable = 1'b1;
    run(100);
    // Command held while busy, then a no-op command.
    send(2, 1'b0);
    run(3);
    send(9, 1'b0);
    run(200);
    send(m_duty, 1'b0);
    run(10);
    // Reset mid-ramp.
    send(0, 1'b0);
    run(45);
    do_reset();
    enable = 1'b1;
    run(30);
    // Random phase.
    for (int k = 0; k < 60; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      if (!cmd_valid) send(($urandom_range(0, 7) == 0) ? $urandom_range(0, 255)
                                                        : $urandom_range(0, P),
                           1'($urandom_range(0, 1)));
      run($urandom_range(1, 90));
      if ($urandom_range(0, 19) == 0) begin
        cmd_valid = 1'b0;
        do_reset();
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
